// File: rtl/fpga_tile_param.sv
// fpga_tile_param - parametrised logic tile.
//
// A connection block picks LUT_K tracks off the incoming routing channel to drive a
// K-input LUT. The LUT output goes straight out or through a flip-flop. A switch box then
// drives every outgoing track from one of three sources or from the CLB result:
//   - the same track on the opposite side
//   - the same track on the next side
//   - the same track on the previous side
//
// Configuration arrives serially on a scan chain. Tiles are daisy-chained through
// cfg_in/cfg_out. Bits collect in a shadow register, and the shadow is copied into the
// active configuration in a single COMMIT cycle. This keeps the running function intact
// while a new word is loaded.
//
// Optional feature macro: TILE_CFG_PARITY_EN. When it is defined:
//   - the config word carries one trailing even-parity bit
//   - a word with bad parity is refused at COMMIT
//   - a refused word raises cfg_err
//
// Ports
//   clk       tile clock
//   reset     asynchronous active-low reset
//   cfg_en    shift enable, one config bit per cycle while high
//   cfg_in    serial config data in
//   cfg_out   serial config data out (shadow bit 0)
//   cfg_busy  high while shifting or committing
//   cfg_done  an active configuration is valid
//   cfg_err   parity failure on the last commit (always 0 without the macro)
//   tile_in   incoming tracks, track (side s, index t) at bit s*CHAN_W+t, sides N,E,S,W
//   tile_out  outgoing tracks, same numbering
module fpga_tile_param #(
  parameter int CHAN_W = 2,
  parameter int LUT_K  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_en,
  input  logic                cfg_in,
  output logic                cfg_out,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [4*CHAN_W-1:0] tile_in,
  output logic [4*CHAN_W-1:0] tile_out
);
  localparam int NTRK     = 4 * CHAN_W;
  localparam int SEL_W    = $clog2(NTRK);
  localparam int LUT_N    = 2 ** LUT_K;
  localparam int CFG_BITS = LUT_N + 1 + LUT_K * SEL_W + 3 * NTRK;
`ifdef TILE_CFG_PARITY_EN
  localparam int WORD_BITS = CFG_BITS + 1;
`else
  localparam int WORD_BITS = CFG_BITS;
`endif
  localparam int CNT_W    = $clog2(WORD_BITS + 2);
  localparam int FFSEL_AT = LUT_N;
  localparam int CB_BASE  = LUT_N + 1;
  localparam int SB_BASE  = CB_BASE + LUT_K * SEL_W;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, RUN} state_e;

  state_e                 state_q, state_d;
  logic [WORD_BITS-1:0]   shadow_q, shadow_d;
  logic [CFG_BITS-1:0]    active_q, active_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   lutFf_q, lutFf_d;
  logic                   cfgDone_q, cfgDone_d;
`ifdef TILE_CFG_PARITY_EN
  logic                   cfgErr_q, cfgErr_d;
`endif

  logic [LUT_K-1:0]       lutIn;
  logic [LUT_N-1:0]       lutTruth;
  logic                   lutOut;
  logic                   clbOut;
  logic [NTRK-1:0]        sbOut;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      active_q  <= '0;
      count_q   <= '0;
      lutFf_q   <= 1'b0;
      cfgDone_q <= 1'b0;
`ifdef TILE_CFG_PARITY_EN
      cfgErr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      count_q   <= count_d;
      lutFf_q   <= lutFf_d;
      cfgDone_q <= cfgDone_d;
`ifdef TILE_CFG_PARITY_EN
      cfgErr_q  <= cfgErr_d;
`endif
    end
  end

  // The count includes the bit shifted on the cycle SHIFT is entered.
  // Reaching WORD_BITS therefore lands on COMMIT exactly after the last shift.
  // The FF only tracks the LUT once a configuration is live.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    count_d   = count_q;
    cfgDone_d = cfgDone_q;
    lutFf_d   = cfgDone_q ? lutOut : 1'b0;
`ifdef TILE_CFG_PARITY_EN
    cfgErr_d  = cfgErr_q;
`endif
    case (state_q)
      IDLE, RUN: begin
        if (cfg_en) begin
          shadow_d = {cfg_in, shadow_q[WORD_BITS-1:1]};
          count_d  = CNT_W'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cfg_en) begin
          shadow_d = {cfg_in, shadow_q[WORD_BITS-1:1]};
          count_d  = count_q + CNT_W'(1);
          if (count_q == CNT_W'(WORD_BITS - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
`ifdef TILE_CFG_PARITY_EN
        if (^shadow_q == 1'b0) begin
          active_d  = shadow_q[CFG_BITS-1:0];
          cfgDone_d = 1'b1;
          lutFf_d   = 1'b0;
          cfgErr_d  = 1'b0;
          state_d   = RUN;
        end else begin
          cfgErr_d  = 1'b1;
          state_d   = cfgDone_q ? RUN : IDLE;
        end
`else
        active_d  = shadow_q[CFG_BITS-1:0];
        cfgDone_d = 1'b1;
        lutFf_d   = 1'b0;
        state_d   = RUN;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Connection block: a select that points past the last track reads as 0.
  for (genvar gi = 0; gi < LUT_K; gi++) begin : g_cb
    logic [SEL_W-1:0] cbSel;
    assign cbSel     = active_q[CB_BASE + gi*SEL_W +: SEL_W];
    assign lutIn[gi] = (int'(cbSel) < NTRK) ? tile_in[cbSel] : 1'b0;
  end

  assign lutTruth = active_q[LUT_N-1:0];
  assign lutOut   = lutTruth[lutIn];
  assign clbOut   = active_q[FFSEL_AT] ? lutFf_q : lutOut;

  // Switch box: field {en, sel[1:0]} per outgoing track.
  for (genvar gs = 0; gs < 4; gs++) begin : g_side
    for (genvar gt = 0; gt < CHAN_W; gt++) begin : g_trk
      localparam int OUT_IDX = gs * CHAN_W + gt;
      logic [2:0] sbFld;
      logic       sbSrc;
      assign sbFld = active_q[SB_BASE + 3*OUT_IDX +: 3];
      always_comb begin
        case (sbFld[1:0])
          2'd0:    sbSrc = tile_in[((gs + 2) % 4) * CHAN_W + gt];
          2'd1:    sbSrc = tile_in[((gs + 1) % 4) * CHAN_W + gt];
          2'd2:    sbSrc = tile_in[((gs + 3) % 4) * CHAN_W + gt];
          default: sbSrc = clbOut;
        endcase
      end
      assign sbOut[OUT_IDX] = sbFld[2] & sbSrc;
    end
  end

  assign tile_out = cfgDone_q ? sbOut : '0;
  assign cfg_out  = shadow_q[0];
  assign cfg_busy = (state_q == SHIFT) || (state_q == COMMIT);
  assign cfg_done = cfgDone_q;
`ifdef TILE_CFG_PARITY_EN
  assign cfg_err  = cfgErr_q;
`else
  assign cfg_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_tile_param.sv
// Testbench for fpga_tile_param (default parameters).
//
// The reference model treats the scan chain as a queue of the most recent WORD_BITS bits.
// At commit it decodes that queue into named fields:
//   - truth table
//   - FF select
//   - connection selects
//   - switch enables and sources
// Expected tile outputs are computed from those fields and the routing geometry.
module tb_fpga_tile_param;
  localparam int CHAN_W   = 2;
  localparam int LUT_K    = 4;
  localparam int NTRK     = 4 * CHAN_W;
  localparam int SEL_W    = $clog2(NTRK);
  localparam int LUT_N    = 2 ** LUT_K;
  localparam int CFG_BITS = LUT_N + 1 + LUT_K * SEL_W + 3 * NTRK;
`ifdef TILE_CFG_PARITY_EN
  localparam int WORD_BITS = CFG_BITS + 1;
`else
  localparam int WORD_BITS = CFG_BITS;
`endif
  localparam int CB_BASE  = LUT_N + 1;
  localparam int SB_BASE  = CB_BASE + LUT_K * SEL_W;

  logic            clk;
  logic            reset;
  logic            cfg_en;
  logic            cfg_in;
  logic            cfg_out;
  logic            cfg_busy;
  logic            cfg_done;
  logic            cfg_err;
  logic [NTRK-1:0] tile_in;
  logic [NTRK-1:0] tile_out;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  // Reference model state
  bit             hist[$];
  int             mCount;
  bit             mBusy, mPending, mDone, mErr, mFf;
  bit [LUT_N-1:0] mTruth;
  bit             mFfSel;
  int             mCb[LUT_K];
  bit             mSbEn[NTRK];
  int             mSbSel[NTRK];

  fpga_tile_param #(.CHAN_W(CHAN_W), .LUT_K(LUT_K)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .tile_in(tile_in), .tile_out(tile_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    for (int i = 0; i < WORD_BITS; i++) hist.push_back(1'b0);
    mCount = 0; mBusy = 0; mPending = 0; mDone = 0; mErr = 0; mFf = 0;
    mTruth = '0; mFfSel = 0;
    for (int i = 0; i < LUT_K; i++) mCb[i] = 0;
    for (int o = 0; o < NTRK; o++) begin mSbEn[o] = 0; mSbSel[o] = 0; end
  endtask

  task automatic decodeHist();
    for (int j = 0; j < LUT_N; j++) mTruth[j] = hist[j];
    mFfSel = hist[LUT_N];
    for (int i = 0; i < LUT_K; i++) begin
      mCb[i] = 0;
      for (int k = 0; k < SEL_W; k++) if (hist[CB_BASE + i*SEL_W + k]) mCb[i] += (1 << k);
    end
    for (int o = 0; o < NTRK; o++) begin
      mSbSel[o] = (hist[SB_BASE + 3*o] ? 1 : 0) + (hist[SB_BASE + 3*o + 1] ? 2 : 0);
      mSbEn[o]  = hist[SB_BASE + 3*o + 2];
    end
  endtask

  function automatic bit parityOk();
`ifdef TILE_CFG_PARITY_EN
    bit p = 0;
    foreach (hist[i]) p ^= hist[i];
    return p == 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit lutNow(input logic [NTRK-1:0] tin);
    int addr = 0;
    for (int i = 0; i < LUT_K; i++)
      if (mCb[i] < NTRK && tin[mCb[i]] == 1'b1) addr += (1 << i);
    return mTruth[addr];
  endfunction

  function automatic logic [NTRK-1:0] modelOut(input logic [NTRK-1:0] tin);
    logic [NTRK-1:0] r;
    bit clb;
    int o, srcSide;
    r = '0;
    if (!mDone) return r;
    clb = mFfSel ? mFf : lutNow(tin);
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < CHAN_W; t++) begin
        o = s * CHAN_W + t;
        if (mSbEn[o]) begin
          if (mSbSel[o] == 3) r[o] = clb;
          else begin
            srcSide = (mSbSel[o] == 0) ? (s + 2) % 4 : (mSbSel[o] == 1) ? (s + 1) % 4 : (s + 3) % 4;
            r[o] = tin[srcSide * CHAN_W + t];
          end
        end
      end
    end
    return r;
  endfunction

  // Effect of one rising clock edge on the model.
  task automatic updateModel(input logic en, input logic b, input logic [NTRK-1:0] tin);
    if (mPending) begin
      mPending = 0;
      mBusy    = 0;
      if (parityOk()) begin
        decodeHist();
        mDone = 1; mFf = 0; mErr = 0;
      end else begin
        mErr = 1;
        mFf  = mDone ? lutNow(tin) : 1'b0;
      end
    end else begin
      mFf = mDone ? lutNow(tin) : 1'b0;
      if (en) begin
        if (!mBusy) begin mBusy = 1; mCount = 0; end
        hist.push_back(b);
        void'(hist.pop_front());
        mCount++;
        if (mCount == WORD_BITS) mPending = 1;
      end
    end
  endtask

  task automatic checkOutput(input logic [NTRK-1:0] tin);
    chk("tile_out", 32'(tile_out), 32'(modelOut(tin)));
    chk("cfg_busy", 32'(cfg_busy), 32'(mBusy));
    chk("cfg_done", 32'(cfg_done), 32'(mDone));
    chk("cfg_err",  32'(cfg_err),  32'(mErr));
    chk("cfg_out",  32'(cfg_out),  32'(hist[0]));
  endtask

  // One clock cycle: drive at the falling edge, check, then let the rising edge act.
  // A non-negative expBit0 adds a directed check on tile_out[0].
  task automatic applyStimulus(input logic en, input logic b, input logic [NTRK-1:0] tin,
                               input int expBit0);
    @(negedge clk);
    cfg_en = en; cfg_in = b; tile_in = tin;
    #1;
    checkOutput(tin);
    if (expBit0 >= 0) chk("tile_out0", 32'(tile_out[0]), 32'(expBit0));
    @(posedge clk);
    updateModel(en, b, tin);
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    cfg_en = 1'b0;
    reset  = 1'b0;
    #1;
    modelReset();
    checkOutput(tile_in);
    chk("rst_tile_out", 32'(tile_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic shiftBits(input logic [WORD_BITS-1:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) applyStimulus(1'b1, w[i], NTRK'($urandom), -1);
  endtask

  // Full load; cfg_en stays high through the COMMIT cycle to show it is ignored there.
  task automatic loadWord(input logic [WORD_BITS-1:0] w);
    shiftBits(w, 0, WORD_BITS - 1);
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), NTRK'($urandom), -1);
  endtask

  task automatic runRandom(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, NTRK'($urandom), -1);
  endtask

  function automatic logic [WORD_BITS-1:0] withParity(input logic [CFG_BITS-1:0] c);
`ifdef TILE_CFG_PARITY_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  // AND of tracks 0..3 driven onto outgoing track (N,0)
  function automatic logic [CFG_BITS-1:0] andCfg(input logic ffSel);
    logic [CFG_BITS-1:0] c;
    c = '0;
    c[LUT_N-1:0] = LUT_N'(16'h8000);
    c[LUT_N] = ffSel;
    for (int i = 0; i < LUT_K; i++) c[CB_BASE + i*SEL_W +: SEL_W] = SEL_W'(i);
    c[SB_BASE +: 3] = 3'b111;
    return c;
  endfunction

  function automatic logic [CFG_BITS-1:0] randCfg();
    logic [CFG_BITS-1:0] c;
    for (int i = 0; i < CFG_BITS; i++) c[i] = 1'($urandom_range(0, 1));
    return c;
  endfunction

  initial begin
    logic [WORD_BITS-1:0] w;
    reset = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0; tile_in = '0;
    modelReset();

    phase = "reset";
    @(negedge clk);
    #1;
    checkOutput(tile_in);
    reset = 1'b1;

    phase = "t1_load";
    loadWord(withParity(andCfg(1'b0)));
    phase = "t1_run";
    applyStimulus(1'b0, 1'b0, 8'h0F, 1);
    applyStimulus(1'b0, 1'b0, 8'hFF, 1);
    applyStimulus(1'b0, 1'b0, 8'h0E, 0);
    applyStimulus(1'b0, 1'b0, 8'h07, 0);
    applyStimulus(1'b0, 1'b0, 8'hF0, 0);
    runRandom(8);

    phase = "t2_load";
    loadWord(withParity(andCfg(1'b1)));
    phase = "t2_run";
    applyStimulus(1'b0, 1'b0, 8'hFF, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    applyStimulus(1'b0, 1'b0, 8'h0F, 0);
    applyStimulus(1'b0, 1'b0, 8'h0B, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 0);
    runRandom(8);

    phase = "t3_pause";
    w = withParity(randCfg());
    shiftBits(w, 0, 19);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), NTRK'($urandom), -1);
    shiftBits(w, 20, WORD_BITS - 1);
    applyStimulus(1'b0, 1'b0, NTRK'($urandom), -1);
    runRandom(10);

    phase = "t4_reconfig";
    for (int n = 0; n < 2; n++) begin
      loadWord(withParity(randCfg()));
      runRandom(10);
    end

    phase = "t5_reset_mid";
    w = withParity(randCfg());
    shiftBits(w, 0, 29);
    applyReset();
    phase = "t5_reload";
    loadWord(withParity(randCfg()));
    runRandom(12);

`ifdef TILE_CFG_PARITY_EN
    phase = "t6_bad_parity";
    w = withParity(randCfg());
    w[WORD_BITS-1] = ~w[WORD_BITS-1];
    loadWord(w);
    runRandom(8);
    phase = "t6_good_parity";
    loadWord(withParity(randCfg()));
    runRandom(8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
